// File: rtl/wb_search_ctrl.sv
// wb_search_ctrl
//   Wishbone slave that supervises PARALLEL_UNITS search units. It latches each
//   unit's best energy/sequence when that unit reports done. It keeps a sticky
//   done status with write-one-to-clear, raises a level interrupt, issues
//   per-unit start pulses and drives a soft reset to the units.
//
// Ports
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   wbs_*                Wishbone slave (cyc/stb/we/sel/adr/dat in, ack/dat out)
//   o_rst                soft reset to units (CFG[0])
//   o_start[PU]          one-cycle start pulse per unit
//   o_irq                level interrupt
//   i_seq[PU*72]         per-unit best sequence
//   i_e[PU*E_WIDTH]      per-unit best energy
//   i_done[PU]           per-unit done level
//
// Register map (offset from BASE_ADR)
//   0x000 STATUS  sticky done, W1C     0x004 CFG      RW, byte lanes
//   0x008 IRQ_EN  RW                   0x00C START    WO, reads 0
//   0x010 LIVE    raw i_done           0x100+16*u     E, seq lo, seq mid, seq hi
module wb_search_ctrl #(
   parameter logic [31:0] BASE_ADR       = 32'h3000_0000,
   parameter int          E_WIDTH        = 16,
   parameter int          PARALLEL_UNITS = 4
) (
   input  logic                               wb_clk_i,
   input  logic                               wb_rst_i,
   input  logic                               wbs_stb_i,
   input  logic                               wbs_cyc_i,
   input  logic                               wbs_we_i,
   input  logic [3:0]                         wbs_sel_i,
   input  logic [31:0]                        wbs_adr_i,
   input  logic [31:0]                        wbs_dat_i,
   output logic                               wbs_ack_o,
   output logic [31:0]                        wbs_dat_o,
   output logic                               o_rst,
   output logic [PARALLEL_UNITS-1:0]          o_start,
   output logic                               o_irq,
   input  logic [PARALLEL_UNITS*72-1:0]       i_seq,
   input  logic [PARALLEL_UNITS*E_WIDTH-1:0]  i_e,
   input  logic [PARALLEL_UNITS-1:0]          i_done
);

   localparam int PU = PARALLEL_UNITS;

   logic [31:0]        cfg;
   logic [PU-1:0]      irq_en;
   logic [PU-1:0]      status;
   logic [PU-1:0]      status_nxt;
   logic [PU-1:0]      done_q;
   logic [PU-1:0]      armed;
   logic [PU-1:0]      rise;
   logic [PU-1:0]      lane_en;
   logic [PU-1:0]      w1c_clr;
   logic [PU-1:0]      start_set;
   logic [PU-1:0]      clr;
   logic [PU-1:0]      capture;
   logic [E_WIDTH-1:0] snap_e   [PU];
   logic [71:0]        snap_seq [PU];

   logic        req;
   logic        wr_fire;
   logic        rd_load;
   logic [11:0] off;
   logic [31:0] rd_data;

   assign req     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:12] == BASE_ADR[31:12]);
   assign off     = wbs_adr_i[11:0];
   // Writes commit on the edge that ends the ack cycle; read data is loaded on
   // the edge that raises ack so it is valid alongside it.
   assign wr_fire = wbs_ack_o & req & wbs_we_i;
   assign rd_load = req & ~wbs_ack_o & ~wbs_we_i;

   // Bit u of a per-unit register lives in byte lane u/8.
   for (genvar g = 0; g < PU; g++) begin : g_lane
      assign lane_en[g] = wbs_sel_i[g/8];
   end

   // An i_done that is already high when reset is released is not an edge:
   // each unit must be seen low at least once before a rise counts.
   assign rise = i_done & ~done_q & armed;

   always_comb begin
      w1c_clr   = '0;
      start_set = '0;
      if (wr_fire && off == 12'h000)
         w1c_clr = wbs_dat_i[PU-1:0] & lane_en;
      if (wr_fire && off == 12'h00C && !cfg[0])
         start_set = wbs_dat_i[PU-1:0] & lane_en;
      clr = w1c_clr | start_set;
      // A coincident done edge beats a clear and refreshes the snapshot.
      capture    = rise & (~status | clr);
      status_nxt = cfg[0] ? '0 : ((status & ~clr) | rise);
   end

   always_comb begin
      rd_data = '0;
      if (off[11:8] == 4'h1 && off[1:0] == 2'b00) begin
         for (int u = 0; u < PU; u++) begin
            if (off[7:4] == u[3:0]) begin
               case (off[3:2])
                  2'd0:    rd_data[E_WIDTH-1:0] = snap_e[u];
                  2'd1:    rd_data = snap_seq[u][31:0];
                  2'd2:    rd_data = snap_seq[u][63:32];
                  default: rd_data[7:0] = snap_seq[u][71:64];
               endcase
            end
         end
      end else begin
         case (off)
            12'h000: rd_data[PU-1:0] = status;
            12'h004: rd_data         = cfg;
            12'h008: rd_data[PU-1:0] = irq_en;
            12'h010: rd_data[PU-1:0] = i_done;
            default: rd_data         = '0;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         cfg       <= '0;
         irq_en    <= '0;
         status    <= '0;
         done_q    <= '0;
         armed     <= '0;
         o_start   <= '0;
         o_irq     <= 1'b0;
         for (int u = 0; u < PU; u++) begin
            snap_e[u]   <= '0;
            snap_seq[u] <= '0;
         end
      end else begin
         wbs_ack_o <= req & ~wbs_ack_o;
         if (rd_load)
            wbs_dat_o <= rd_data;
         done_q <= i_done;
         armed  <= armed | ~i_done;
         if (wr_fire && off == 12'h004) begin
            for (int b = 0; b < 4; b++)
               if (wbs_sel_i[b])
                  cfg[8*b +: 8] <= wbs_dat_i[8*b +: 8];
         end
         if (wr_fire && off == 12'h008) begin
            for (int u = 0; u < PU; u++)
               if (lane_en[u])
                  irq_en[u] <= wbs_dat_i[u];
         end
         o_start <= start_set;
         o_irq   <= |(status & irq_en & {PU{~cfg[1]}});
         status  <= status_nxt;
         for (int u = 0; u < PU; u++) begin
            if (cfg[0]) begin
               snap_e[u]   <= '0;
               snap_seq[u] <= '0;
            end else if (capture[u]) begin
               snap_e[u]   <= i_e[u*E_WIDTH +: E_WIDTH];
               snap_seq[u] <= i_seq[u*72 +: 72];
            end
         end
      end
   end

   assign o_rst = cfg[0];

endmodule
